// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive bit recovery: DPLL-style phase, NRZI, unstuff, EOP.
// Optional USB_RX_ERR_COUNT_EN adds a saturating err_count output.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus_sync,
  input  logic       d_minus_sync,
  input  logic       enable,
  output logic       bit_valid,
  output logic       bit_data,
  output logic       eop,
  output logic       rx_err
`ifdef USB_RX_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMP = PW'(SAMPLE_POINT);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECEIVE,
    S_SE0_1,
    S_SE0_2,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          prev_dp_q, prev_dp_d;
  logic          last_sample_q, last_sample_d;
  logic [2:0]    ones_cnt_q, ones_cnt_d;
  logic          j_seen_q, j_seen_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_data_q, bit_data_d;
  logic          eop_q, eop_d;
  logic          rx_err_q, rx_err_d;

  logic line_edge;
  logic sample;
  logic is_se0;
  logic is_j;
  logic decoded;

  // Line classification and sample strobe
  always_comb begin
    line_edge = d_plus_sync != prev_dp_q;
    sample    = (phase_q == PH_SAMP) && !line_edge;
    is_se0    = !d_plus_sync && !d_minus_sync;
    is_j      = d_plus_sync && !d_minus_sync;
    decoded   = d_plus_sync == last_sample_q;
  end

  // Next state: phase tracking, NRZI/unstuff, EOP sequencing
  always_comb begin
    state_d       = state_q;
    prev_dp_d     = d_plus_sync;
    last_sample_d = last_sample_q;
    ones_cnt_d    = ones_cnt_q;
    j_seen_d      = j_seen_q;
    bit_valid_d   = 1'b0;
    bit_data_d    = bit_data_q;
    eop_d         = 1'b0;
    rx_err_d      = 1'b0;

    if (line_edge)
      phase_d = PH_ONE;
    else if (phase_q == PH_LAST)
      phase_d = '0;
    else
      phase_d = phase_q + PH_ONE;

    if (!enable) begin
      state_d       = S_IDLE;
      phase_d       = '0;
      ones_cnt_d    = '0;
      j_seen_d      = 1'b0;
      last_sample_d = 1'b1;
    end else begin
      if (sample && !is_se0)
        last_sample_d = d_plus_sync;

      unique case (state_q)
        S_IDLE: begin
          if (line_edge && !d_plus_sync) begin
            state_d       = S_RECEIVE;
            last_sample_d = 1'b1;
            ones_cnt_d    = '0;
          end
        end
        S_RECEIVE: begin
          if (sample) begin
            if (is_se0) begin
              state_d = S_SE0_1;
            end else if (ones_cnt_q == 3'd6) begin
              if (!decoded) begin
                ones_cnt_d = '0;
              end else begin
                rx_err_d = 1'b1;
                state_d  = S_WAIT_IDLE;
                j_seen_d = 1'b0;
              end
            end else begin
              bit_valid_d = 1'b1;
              bit_data_d  = decoded;
              ones_cnt_d  = decoded ? ones_cnt_q + 3'd1 : 3'd0;
            end
          end
        end
        S_SE0_1: begin
          if (sample) begin
            if (is_se0) begin
              state_d = S_SE0_2;
            end else begin
              rx_err_d = 1'b1;
              state_d  = S_WAIT_IDLE;
              j_seen_d = 1'b0;
            end
          end
        end
        S_SE0_2: begin
          if (sample) begin
            if (is_j) begin
              eop_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              rx_err_d = 1'b1;
              state_d  = S_WAIT_IDLE;
              j_seen_d = 1'b0;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (sample) begin
            if (is_j && j_seen_q) begin
              state_d  = S_IDLE;
              j_seen_d = 1'b0;
            end else begin
              j_seen_d = is_j;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      prev_dp_q     <= 1'b1;
      last_sample_q <= 1'b1;
      ones_cnt_q    <= '0;
      j_seen_q      <= 1'b0;
      bit_valid_q   <= 1'b0;
      bit_data_q    <= 1'b0;
      eop_q         <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      prev_dp_q     <= prev_dp_d;
      last_sample_q <= last_sample_d;
      ones_cnt_q    <= ones_cnt_d;
      j_seen_q      <= j_seen_d;
      bit_valid_q   <= bit_valid_d;
      bit_data_q    <= bit_data_d;
      eop_q         <= eop_d;
      rx_err_q      <= rx_err_d;
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_data  = bit_data_q;
  assign eop       = eop_q;
  assign rx_err    = rx_err_q;

`ifdef USB_RX_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating count of rx_err pulses
  always_comb begin
    err_count_d = err_count_q;
    if (rx_err_q && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count_q <= '0;
    else
      err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
